// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO in front of a UART transmitter.
// Queues bytes from the system side and launches them one at a time with a
// single-cycle tx_start. Each frame is supervised until tx_done arrives or a
// timeout expires. All outputs are registered.
module uart_tx_feeder #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              timeout_err,
    output logic              active,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    input  logic              tx_busy
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  TMR_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  TMR_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  TMR_ZERO = CNT_W'(0);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          mem_q [DEPTH];
    logic [7:0]          mem_d [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                overflow_q, overflow_d;
    logic                active_q, active_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]    tmr_q, tmr_d;

    logic                launch_s;
    logic                push_s;

    // The transmitter's busy flag is observed only; it never gates a launch.
    logic                tx_busy_unused;
    assign tx_busy_unused = tx_busy;

    // Launch and accepted-push decisions; flush blocks both.
    always_comb begin
        launch_s = (state_q == IDLE) && enable && !empty_q && !flush;
        push_s   = wr_en && !full_q && !flush;
    end

    // FIFO next state: storage, pointers, occupancy and sticky overflow.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = PTR_ZERO;
            rd_ptr_d   = PTR_ZERO;
            count_d    = CNT_ZERO;
            overflow_d = 1'b0;
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (launch_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, launch_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            // A write against a full FIFO is dropped even if a pop frees a slot now.
            if (wr_en && full_q) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == CNT_ZERO);
    end

    // Launch/supervision FSM next state and registered transmitter controls.
    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch_s) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                    tmr_d      = TMR_ZERO;
                    state_d    = WAIT_DONE;
                end else begin
                    tx_start_d = 1'b0;
                end
            end
            WAIT_DONE: begin
                // tx_done takes precedence over an expiring timer.
                if (tx_done) begin
                    state_d = IDLE;
                end else if (tmr_q == TMR_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        active_d = (state_d == WAIT_DONE) || !empty_d;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_q         <= '{default: 8'h00};
            wr_ptr_q      <= PTR_ZERO;
            rd_ptr_q      <= PTR_ZERO;
            count_q       <= CNT_ZERO;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            overflow_q    <= 1'b0;
            active_q      <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            timeout_err_q <= 1'b0;
            tmr_q         <= TMR_ZERO;
        end else begin
            state_q       <= state_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            overflow_q    <= overflow_d;
            active_q      <= active_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            timeout_err_q <= timeout_err_d;
            tmr_q         <= tmr_d;
        end
    end

    assign full        = full_q;
    assign empty       = empty_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;
    assign active      = active_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: one task per scenario, inline checks.
module tb_uart_tx_feeder;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int TO     = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic            flush;
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic            timeout_err;
    logic            active;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_done;
    logic            tx_busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
        .count(count), .overflow(overflow), .timeout_err(timeout_err),
        .active(active), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done(tx_done), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a tx_start pulse.
    task automatic wait_start(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            tick();
            if (tx_start === 1'b1) seen = 1'b1;
        end
    endtask

    // Pulse tx_done for one edge.
    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; flush = 1'b0; wr_en = 1'b0;
        wr_data = 8'h00; tx_done = 1'b0; tx_busy = 1'b0;
        tick(); tick();
        n_checks++;
        if ({empty, full, count, overflow, timeout_err, tx_start, tx_data, active} !==
            {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got e=%b f=%b c=%0d ov=%b to=%b st=%b d=%h a=%b, want e=1 f=0 c=0 ov=0 to=0 st=0 d=00 a=0",
                     empty, full, count, overflow, timeout_err, tx_start, tx_data, active);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        enable = 1'b1;
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if ({count, empty, tx_start} !== {5'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_push: got c=%0d e=%b st=%b, want c=1 e=0 st=0", count, empty, tx_start);
        end
        tick();
        n_checks++;
        if ({tx_start, tx_data, active, empty} !== {1'b1, 8'hA5, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_launch: got st=%b d=%h a=%b e=%b, want st=1 d=a5 a=1 e=1", tx_start, tx_data, active, empty);
        end
        tick();
        n_checks++;
        if ({tx_start, tx_data, active} !== {1'b0, 8'hA5, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_pulse_width: got st=%b d=%h a=%b, want st=0 d=a5 a=1", tx_start, tx_data, active);
        end
        for (int i = 0; i < 8; i++) tick();
        pulse_done();
        n_checks++;
        if ({active, empty, tx_start, timeout_err, tx_data} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'hA5}) begin
            n_fail++;
            $display("FAIL basic_done: got a=%b e=%b st=%b to=%b d=%h, want a=0 e=1 st=0 to=0 d=a5",
                     active, empty, tx_start, timeout_err, tx_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03;
        enable = 1'b1;
        wr_en = 1'b1; wr_data = 8'h01; tick();
        wr_data = 8'h02; tick();
        n_checks++;
        if ({tx_start, tx_data, count} !== {1'b1, 8'h01, 5'd1}) begin
            n_fail++;
            $display("FAIL b2b_first_launch: got st=%b d=%h c=%0d, want st=1 d=01 c=1", tx_start, tx_data, count);
        end
        wr_data = 8'h03; tick();
        wr_en = 1'b0;
        n_checks++;
        if ({tx_start, tx_data, count} !== {1'b0, 8'h01, 5'd2}) begin
            n_fail++;
            $display("FAIL b2b_queue: got st=%b d=%h c=%0d, want st=0 d=01 c=2", tx_start, tx_data, count);
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                tick();
                n_checks++;
                if ({tx_start, tx_data} !== {1'b1, exp_b[i]}) begin
                    n_fail++;
                    $display("FAIL b2b_launch_%0d: got st=%b d=%h, want st=1 d=%h", i, tx_start, tx_data, exp_b[i]);
                end
            end
            for (int k = 0; k < 2; k++) begin
                tick();
                n_checks++;
                if ({tx_start, tx_data} !== {1'b0, exp_b[i]}) begin
                    n_fail++;
                    $display("FAIL b2b_stable_%0d: got st=%b d=%h, want st=0 d=%h", i, tx_start, tx_data, exp_b[i]);
                end
            end
            pulse_done();
            n_checks++;
            if (tx_start !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_idle_gap_%0d: got st=%b, want st=0", i, tx_start);
            end
        end
        n_checks++;
        if ({active, count} !== {1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL b2b_end: got a=%b c=%0d, want a=0 c=0", active, count);
        end
    endtask

    task automatic test_full_overflow();
        bit seen;
        enable = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
            tick();
            if (i == DEPTH - 1) begin
                n_checks++;
                if ({full, overflow, count} !== {1'b1, 1'b0, 5'd16}) begin
                    n_fail++;
                    $display("FAIL full_reached: got f=%b ov=%b c=%0d, want f=1 ov=0 c=16", full, overflow, count);
                end
            end
        end
        wr_en = 1'b0;
        n_checks++;
        if ({full, overflow, count, tx_start} !== {1'b1, 1'b1, 5'd16, 1'b0}) begin
            n_fail++;
            $display("FAIL overflow_set: got f=%b ov=%b c=%0d st=%b, want f=1 ov=1 c=16 st=0", full, overflow, count, tx_start);
        end
        enable = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wait_start(4, seen);
            n_checks++;
            if (!seen || tx_data !== 8'h10 + 8'(i)) begin
                n_fail++;
                $display("FAIL drain_%0d: got seen=%b d=%h, want seen=1 d=%h", i, seen, tx_data, 8'h10 + 8'(i));
            end
            pulse_done();
        end
        tick();
        n_checks++;
        if ({tx_start, empty, overflow, active} !== {1'b0, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL drain_end: got st=%b e=%b ov=%b a=%b, want st=0 e=1 ov=1 a=0", tx_start, empty, overflow, active);
        end
        flush = 1'b1; tick(); flush = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clears_ov: got ov=%b, want ov=0", overflow);
        end
    endtask

    task automatic test_simultaneous();
        enable = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_data = 8'h20 + 8'(i);
            tick();
        end
        enable = 1'b1; wr_en = 1'b1; wr_data = 8'hFF;
        tick();
        wr_en = 1'b0; enable = 1'b0;
        n_checks++;
        if ({tx_start, tx_data, count, overflow, full} !== {1'b1, 8'h20, 5'd15, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL pop_vs_full_write: got st=%b d=%h c=%0d ov=%b f=%b, want st=1 d=20 c=15 ov=1 f=0",
                     tx_start, tx_data, count, overflow, full);
        end
        pulse_done();
        flush = 1'b1; tick(); flush = 1'b0;
        n_checks++;
        if ({count, empty, overflow} !== {5'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_queue: got c=%0d e=%b ov=%b, want c=0 e=1 ov=0", count, empty, overflow);
        end
        wr_en = 1'b1; wr_data = 8'h55; tick(); wr_en = 1'b0;
        enable = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if ({tx_start, count, empty} !== {1'b0, 5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_vs_launch: got st=%b c=%0d e=%b, want st=0 c=0 e=1", tx_start, count, empty);
        end
        tick();
        n_checks++;
        if ({tx_start, active} !== {1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_after: got st=%b a=%b, want st=0 a=0", tx_start, active);
        end
    endtask

    task automatic test_timeout();
        int  n;
        bit  found;
        enable = 1'b1;
        wr_en = 1'b1; wr_data = 8'h66; tick();
        wr_data = 8'h77; tick();
        wr_en = 1'b0;
        n_checks++;
        if ({tx_start, tx_data} !== {1'b1, 8'h66}) begin
            n_fail++;
            $display("FAIL to_launch: got st=%b d=%h, want st=1 d=66", tx_start, tx_data);
        end
        n = 0; found = 1'b0;
        while (n < 40 && !found) begin
            tick();
            n++;
            if (timeout_err === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found || n != TO) begin
            n_fail++;
            $display("FAIL to_latency: got found=%b cycles=%0d, want found=1 cycles=%0d", found, n, TO);
        end
        tick();
        n_checks++;
        if ({timeout_err, tx_start, tx_data} !== {1'b0, 1'b1, 8'h77}) begin
            n_fail++;
            $display("FAIL to_next_launch: got to=%b st=%b d=%h, want to=0 st=1 d=77", timeout_err, tx_start, tx_data);
        end
        pulse_done();
        tick();
    endtask

    task automatic test_reset_mid_frame();
        bit seen;
        bit any_start;
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
            tick();
        end
        wr_en = 1'b0; enable = 1'b1;
        tick();
        n_checks++;
        if ({tx_start, tx_data, count} !== {1'b1, 8'hA0, 5'd5}) begin
            n_fail++;
            $display("FAIL rmf_setup: got st=%b d=%h c=%0d, want st=1 d=a0 c=5", tx_start, tx_data, count);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({tx_start, count, empty, overflow, active, tx_data} !== {1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL rmf_async: got st=%b c=%0d e=%b ov=%b a=%b d=%h, want st=0 c=0 e=1 ov=0 a=0 d=00",
                     tx_start, count, empty, overflow, active, tx_data);
        end
        #1;
        rst = 1'b0;
        any_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tx_start !== 1'b0 || active !== 1'b0) any_start = 1'b1;
        end
        n_checks++;
        if (any_start !== 1'b0) begin
            n_fail++;
            $display("FAIL rmf_no_launch: got spurious_activity=%b, want 0", any_start);
        end
        wr_en = 1'b1; wr_data = 8'hB7; tick(); wr_en = 1'b0;
        wait_start(3, seen);
        n_checks++;
        if (!seen || tx_data !== 8'hB7) begin
            n_fail++;
            $display("FAIL rmf_new_write: got seen=%b d=%h, want seen=1 d=b7", seen, tx_data);
        end
        pulse_done();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_full_overflow();
        test_simultaneous();
        test_timeout();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
